// File: rtl/cyclic_coder_ctrl_if.sv
// Word/serial bus between the cyclic coder sequencer and its neighbours:
// word producer (s_*), the external coder (coder_*) and the framed serial line (m_*).
interface cyclic_coder_ctrl_if #(
  parameter int DATA_BITS = 12
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 coder_enable;
  logic                 coder_in;
  logic                 coder_out;
  logic                 m_bit;
  logic                 m_valid;
  logic                 m_sop;
  logic                 m_eop;
  logic                 busy;

  modport master (
    input  s_data, s_valid, coder_out,
    output s_ready, coder_enable, coder_in, m_bit, m_valid, m_sop, m_eop, busy
  );

  modport slave (
    output s_data, s_valid, coder_out,
    input  s_ready, coder_enable, coder_in, m_bit, m_valid, m_sop, m_eop, busy
  );
endinterface

// File: rtl/cyclic_coder_ctrl.sv
// Sequencer for a serial systematic cyclic coder: keeps coder enable block-aligned and frames output.
// Optional CODER_CTRL_STATS_EN adds saturating block/SYNC-cycle counters (stat_blocks, stat_sync).
module cyclic_coder_ctrl #(
  parameter int DATA_BITS  = 12,
  parameter int CHECK_BITS = 4,
  parameter int BLOCK_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CODER_CTRL_STATS_EN
  output logic [15:0] stat_blocks,
  output logic [15:0] stat_sync,
`endif
  cyclic_coder_ctrl_if.master bus
);

  localparam int PW = 4;

  if (BLOCK_LEN != DATA_BITS + CHECK_BITS || BLOCK_LEN != 16) begin : g_bad_len
    $error("cyclic_coder_ctrl: BLOCK_LEN must be 16 and equal DATA_BITS+CHECK_BITS");
  end

  typedef enum logic [1:0] {SYNC, IDLE, DATA, CHECK} state_t;

  state_t               r_state, w_next;
  logic [DATA_BITS-1:0] r_shreg, w_shreg;
  logic [PW-1:0]        r_cnt, w_cnt;
  // Mirrors the coder's free-running bit counter, so it must survive rst.
  logic [PW-1:0]        r_phase = '0;
  logic                 w_enable, w_cin, w_ready, w_valid, w_busy;
  logic                 w_last_phase;

  assign w_last_phase = (r_phase == PW'(BLOCK_LEN - 1));

  always_comb begin
    w_next   = r_state;
    w_shreg  = r_shreg;
    w_cnt    = r_cnt;
    w_enable = 1'b0;
    w_cin    = 1'b0;
    w_ready  = 1'b0;
    w_valid  = 1'b0;
    w_busy   = 1'b0;
    if (!rst) begin
      w_busy = (r_state != IDLE);
      case (r_state)
        SYNC: begin
          w_enable = 1'b1;
          if (w_last_phase) w_next = IDLE;
        end
        IDLE: begin
          w_ready = 1'b1;
          if (bus.s_valid) begin
            w_shreg = bus.s_data;
            w_cnt   = '0;
            w_next  = DATA;
          end
        end
        DATA: begin
          w_enable = 1'b1;
          w_valid  = 1'b1;
          w_cin    = r_shreg[DATA_BITS-1];
          w_shreg  = {r_shreg[DATA_BITS-2:0], 1'b0};
          w_cnt    = r_cnt + 1'b1;
          if (r_cnt == PW'(DATA_BITS - 1)) begin
            w_cnt  = '0;
            w_next = CHECK;
          end
        end
        CHECK: begin
          w_enable = 1'b1;
          w_valid  = 1'b1;
          w_cnt    = r_cnt + 1'b1;
          // Accepting on the last parity bit lets the next block start at phase 0 with no gap.
          if (r_cnt == PW'(CHECK_BITS - 1)) begin
            w_ready = 1'b1;
            w_cnt   = '0;
            if (bus.s_valid) begin
              w_shreg = bus.s_data;
              w_next  = DATA;
            end else begin
              w_next  = IDLE;
            end
          end
        end
        default: w_next = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (r_phase != '0) ? SYNC : IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
    r_shreg <= w_shreg;
  end

  always_ff @(posedge clk) begin
    if (w_enable) r_phase <= r_phase + 1'b1;
  end

  assign bus.s_ready      = w_ready;
  assign bus.coder_enable = w_enable;
  assign bus.coder_in     = w_cin;
  assign bus.m_valid      = w_valid;
  assign bus.m_bit        = w_valid & bus.coder_out;
  assign bus.m_sop        = w_valid && (r_phase == '0);
  assign bus.m_eop        = w_valid && w_last_phase;
  assign bus.busy         = w_busy;

`ifdef CODER_CTRL_STATS_EN
  logic [15:0] r_stat_blocks, r_stat_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_blocks <= '0;
      r_stat_sync   <= '0;
    end else begin
      if (w_valid && w_last_phase && r_stat_blocks != 16'hFFFF)
        r_stat_blocks <= r_stat_blocks + 1'b1;
      if (r_state == SYNC && r_stat_sync != 16'hFFFF)
        r_stat_sync <= r_stat_sync + 1'b1;
    end
  end

  assign stat_blocks = r_stat_blocks;
  assign stat_sync   = r_stat_sync;
`endif

endmodule

// File: tb/tb_cyclic_coder_ctrl.sv
// Directed bench for cyclic_coder_ctrl with a behavioural coder (g(x)=x^4+x+1, 16-phase counter).
module tb_cyclic_coder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cyclic_coder_ctrl_if #(.DATA_BITS(12)) bus ();

`ifdef CODER_CTRL_STATS_EN
  logic [15:0] stat_blocks, stat_sync;
`endif

  cyclic_coder_ctrl #(.DATA_BITS(12), .CHECK_BITS(4), .BLOCK_LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CODER_CTRL_STATS_EN
    .stat_blocks(stat_blocks),
    .stat_sync  (stat_sync),
`endif
    .bus        (bus)
  );

  // Coder model: pass-through for phases 0..11, then shifts out the 4-bit remainder.
  logic [3:0] c_lfsr  = 4'd0;
  logic [3:0] c_phase = 4'd0;
  always @(posedge clk) begin
    if (bus.coder_enable) c_phase <= c_phase + 4'd1;
    if (!bus.coder_enable)    c_lfsr <= 4'd0;
    else if (c_phase < 4'd12) c_lfsr <= {c_lfsr[2:0], 1'b0} ^ ((bus.coder_in ^ c_lfsr[3]) ? 4'b0011 : 4'b0000);
    else                      c_lfsr <= {c_lfsr[2:0], 1'b0};
  end
  assign bus.coder_out = (c_phase < 4'd12) ? bus.coder_in : c_lfsr[3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [11:0] data;
    logic [15:0] cw;
    bit          noise;
  } vec_t;

  vec_t vecs [5];

  task automatic send_block(input vec_t v, input string tag);
    bus.s_data  = v.data;
    bus.s_valid = 1'b1;
    #1;
    chk($sformatf("%s.accept_ready", tag), 16'(bus.s_ready), 16'd1);
    tick;
    bus.s_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (v.noise && i < 15) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data  = 12'($urandom);
      end else begin
        bus.s_valid = 1'b0;
      end
      #1;
      chk($sformatf("%s.valid%0d", tag, i), 16'(bus.m_valid), 16'd1);
      chk($sformatf("%s.bit%0d", tag, i),   16'(bus.m_bit),   16'(v.cw[15-i]));
      chk($sformatf("%s.sop%0d", tag, i),   16'(bus.m_sop),   16'(i == 0));
      chk($sformatf("%s.eop%0d", tag, i),   16'(bus.m_eop),   16'(i == 15));
      chk($sformatf("%s.ready%0d", tag, i), 16'(bus.s_ready), 16'(i == 15));
      tick;
    end
    #1;
    chk($sformatf("%s.after_valid", tag), 16'(bus.m_valid), 16'd0);
    chk($sformatf("%s.after_busy", tag),  16'(bus.busy),    16'd0);
    chk($sformatf("%s.after_ready", tag), 16'(bus.s_ready), 16'd1);
  endtask

  initial begin
    logic [11:0] words [3];
    logic [15:0] cws   [3];
    int          blocks;

    vecs[0] = '{data: 12'h000, cw: 16'h0000, noise: 1'b0};
    vecs[1] = '{data: 12'hA5C, cw: 16'hA5C9, noise: 1'b0};
    vecs[2] = '{data: 12'hFFF, cw: 16'hFFFE, noise: 1'b1};
    vecs[3] = '{data: 12'h001, cw: 16'h0013, noise: 1'b0};
    vecs[4] = '{data: 12'h800, cw: 16'h8001, noise: 1'b1};
    words[0] = 12'h001; cws[0] = 16'h0013;
    words[1] = 12'hFFF; cws[1] = 16'hFFFE;
    words[2] = 12'h800; cws[2] = 16'h8001;
    blocks = 0;

    // Power-up reset with a word offered: nothing may be accepted or driven.
    bus.s_data  = 12'h000;
    bus.s_valid = 1'b1;
    tick;
    tick;
    #1;
    chk("rst.enable",   16'(bus.coder_enable), 16'd0);
    chk("rst.ready",    16'(bus.s_ready),      16'd0);
    chk("rst.valid",    16'(bus.m_valid),      16'd0);
    chk("rst.busy",     16'(bus.busy),         16'd0);
    chk("rst.coder_in", 16'(bus.coder_in),     16'd0);
    bus.s_valid = 1'b0;
    rst = 1'b0;
    tick;
    #1;
    chk("post_rst.busy",   16'(bus.busy),         16'd0);
    chk("post_rst.ready",  16'(bus.s_ready),      16'd1);
    chk("post_rst.enable", 16'(bus.coder_enable), 16'd0);

    for (int k = 0; k < 5; k++) begin
      send_block(vecs[k], $sformatf("vec%0d", k));
      blocks++;
    end

    // Back-to-back blocks with s_valid held.
    bus.s_data  = words[0];
    bus.s_valid = 1'b1;
    #1;
    chk("b2b.accept_ready", 16'(bus.s_ready), 16'd1);
    tick;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) begin
        if (i == 15) begin
          if (b < 2) bus.s_data = words[b+1];
          else       bus.s_valid = 1'b0;
        end
        #1;
        chk($sformatf("b2b%0d.valid%0d", b, i), 16'(bus.m_valid), 16'd1);
        chk($sformatf("b2b%0d.bit%0d", b, i),   16'(bus.m_bit),   16'(cws[b][15-i]));
        chk($sformatf("b2b%0d.sop%0d", b, i),   16'(bus.m_sop),   16'(i == 0));
        chk($sformatf("b2b%0d.eop%0d", b, i),   16'(bus.m_eop),   16'(i == 15));
        if (b < 2) chk($sformatf("b2b%0d.ready%0d", b, i), 16'(bus.s_ready), 16'(i == 15));
        tick;
      end
      blocks++;
    end
    #1;
    chk("b2b.end_valid", 16'(bus.m_valid), 16'd0);
    chk("b2b.end_busy",  16'(bus.busy),    16'd0);

    // Reset at phase 5 of a block.
    bus.s_data  = 12'hA5C;
    bus.s_valid = 1'b1;
    tick;
    bus.s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mid.valid%0d", i), 16'(bus.m_valid), 16'd1);
      chk($sformatf("mid.bit%0d", i),   16'(bus.m_bit),   16'(vecs[1].cw[15-i]));
      tick;
    end
`ifdef CODER_CTRL_STATS_EN
    chk("stats.blocks_before_rst", stat_blocks, 16'(blocks));
`endif
    rst = 1'b1;
    #1;
    chk("mid_rst.valid",  16'(bus.m_valid),      16'd0);
    chk("mid_rst.eop",    16'(bus.m_eop),        16'd0);
    chk("mid_rst.enable", 16'(bus.coder_enable), 16'd0);
    chk("mid_rst.busy",   16'(bus.busy),         16'd0);
    chk("mid_rst.ready",  16'(bus.s_ready),      16'd0);
    tick;
    rst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 12'h3C3;
`ifdef CODER_CTRL_STATS_EN
    #1;
    chk("stats.blocks_after_rst", stat_blocks, 16'd0);
`endif
    for (int k = 0; k < 11; k++) begin
      #1;
      chk($sformatf("sync%0d.busy", k),   16'(bus.busy),         16'd1);
      chk($sformatf("sync%0d.valid", k),  16'(bus.m_valid),      16'd0);
      chk($sformatf("sync%0d.ready", k),  16'(bus.s_ready),      16'd0);
      chk($sformatf("sync%0d.enable", k), 16'(bus.coder_enable), 16'd1);
      tick;
    end
    bus.s_valid = 1'b0;
    #1;
    chk("sync_done.busy",  16'(bus.busy),    16'd0);
    chk("sync_done.ready", 16'(bus.s_ready), 16'd1);
    chk("sync_done.valid", 16'(bus.m_valid), 16'd0);
`ifdef CODER_CTRL_STATS_EN
    chk("stats.sync_cycles", stat_sync, 16'd11);
`endif
    send_block(vecs[1], "realigned");
`ifdef CODER_CTRL_STATS_EN
    chk("stats.blocks_final", stat_blocks, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
